system: RTL and testbench



---
 rtl/system.sv | 158 +++++++++++++++
 tb/tb_system.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/system.sv
`timescale 1ns/1ps
// system: autonomous SPI-master sequencer for an ADXL362-style accelerometer (write POWER_CTL, burst-read axes, stream bytes).
// Define ASCII_HEX_EN to emit each byte as two uppercase hex characters plus a newline.
module system #(
    parameter int         CLK_DIV   = 2,
    parameter logic [7:0] CFG_ADDR  = 8'h2D,
    parameter logic [7:0] CFG_DATA  = 8'h02,
    parameter logic [7:0] DATA_ADDR = 8'h10,
    parameter int         NUM_BYTES = 4,
    parameter int         CS_GAP    = 4
) (
    input  logic       clk,
    input  logic       resetn,
    output logic       trap,
    output logic [7:0] out_byte,
    output logic       out_byte_en,
    input  logic       INT1,
    input  logic       INT2,
    input  logic       MISO,
    output logic       MOSI,
    output logic       CS,
    output logic       SCLK
);
    localparam int DW = 8 * NUM_BYTES;
    localparam logic [6:0] RD_LEN = 7'(17 + 8 * NUM_BYTES);
    localparam logic [15:0] GAP_CLKS = 16'(2 * CS_GAP * CLK_DIV);
`ifdef ASCII_HEX_EN
    localparam int CPB = 3;
`else
    localparam int CPB = 1;
`endif

    typedef enum logic [2:0] {IDLE, WR, GAP1, RD, EMIT, DONE} state_t;

    state_t          r_state = IDLE;
    logic            r_cs    = 1'b1;
    logic            r_sclk  = 1'b0;
    logic            r_mosi  = 1'b0;
    logic            r_fall  = 1'b0;
    logic            r_trap  = 1'b0;
    logic            r_en    = 1'b0;
    logic [7:0]      r_out   = '0;
    logic [15:0]     r_div   = '0;
    logic [15:0]     r_gap   = '0;
    logic [6:0]      r_cnt   = '0;
    logic [23:0]     r_tx    = '0;
    logic [DW-1:0]   r_data  = '0;
    logic [3:0]      r_bcnt  = '0;
    logic [1:0]      r_ci    = '0;

    logic       w_tick;
    logic [6:0] w_total;
    logic [7:0] w_top;
    logic [7:0] w_char;
    logic       w_unused;

    assign w_tick   = r_div == 16'(CLK_DIV - 1);
    assign w_total  = (r_state == WR) ? 7'd24 : RD_LEN;
    assign w_top    = r_data[DW-1 -: 8];
    assign w_unused = ^{INT1, INT2};

`ifdef ASCII_HEX_EN
    function automatic logic [7:0] hex(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction
    assign w_char = (r_ci == 2'd0) ? hex(w_top[7:4]) : (r_ci == 2'd1) ? hex(w_top[3:0]) : 8'h0A;
`else
    assign w_char = w_top;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_cs    <= 1'b1;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
            r_fall  <= 1'b0;
            r_trap  <= 1'b0;
            r_en    <= 1'b0;
            r_out   <= '0;
            r_div   <= '0;
            r_gap   <= '0;
            r_cnt   <= '0;
            r_tx    <= '0;
            r_data  <= '0;
            r_bcnt  <= '0;
            r_ci    <= '0;
        end else begin
            r_fall <= 1'b0;
            case (r_state)
                IDLE, GAP1: begin
                    r_gap <= r_gap + 16'd1;
                    if (r_state == IDLE || r_gap == GAP_CLKS) begin
                        r_state <= (r_state == IDLE) ? WR : RD;
                        r_cs    <= 1'b0;
                        r_mosi  <= 1'b0;  // both command bytes start with a 0 bit
                        r_tx    <= (r_state == IDLE) ? {8'h0A, CFG_ADDR, CFG_DATA} : {8'h0B, DATA_ADDR, 8'h00};
                        r_div   <= '0;
                        r_cnt   <= '0;
                    end
                end
                WR, RD: begin
                    if (r_fall && r_cnt == w_total) begin
                        r_cs    <= 1'b1;
                        r_mosi  <= 1'b0;
                        r_gap   <= '0;
                        r_state <= (r_state == WR) ? GAP1 : EMIT;
                    end else begin
                        // MOSI moves one clk after each falling edge, never on an edge
                        if (r_fall) begin
                            r_mosi <= r_tx[22];
                            r_tx   <= r_tx << 1;
                        end
                        r_div <= w_tick ? '0 : r_div + 16'd1;
                        if (w_tick) begin
                            r_sclk <= !r_sclk;
                            r_fall <= r_sclk;
                            if (!r_sclk) begin
                                r_cnt <= r_cnt + 7'd1;
                                if (r_state == RD && r_cnt >= 7'd17)
                                    r_data <= {r_data[DW-2:0], MISO};
                            end
                        end
                    end
                end
                EMIT: begin
                    if (r_en) begin
                        r_en <= 1'b0;
                    end else begin
                        r_en  <= 1'b1;
                        r_out <= w_char;
                        if (r_ci == 2'(CPB - 1)) begin
                            r_ci   <= '0;
                            r_data <= r_data << 8;
                            r_bcnt <= r_bcnt + 4'd1;
                            if (r_bcnt == 4'(NUM_BYTES - 1))
                                r_state <= DONE;
                        end else begin
                            r_ci <= r_ci + 2'd1;
                        end
                    end
                end
                DONE: begin
                    r_en   <= 1'b0;
                    r_trap <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign trap        = r_trap;
    assign out_byte    = r_out;
    assign out_byte_en = r_en;
    assign MOSI        = r_mosi;
    assign CS          = r_cs;
    assign SCLK        = r_sclk;
endmodule

// File: tb/tb_system.sv
`timescale 1ns/1ps
// tb_system: directed bench for system with an ADXL362-style sensor model returning reg[n]=n.
module tb_system;
    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       MISO = 1'b0;
    logic       INT1 = 1'bx;
    logic       INT2 = 1'bz;
    logic       trap, out_byte_en, MOSI, CS, SCLK;
    logic [7:0] out_byte;

    system dut (
        .clk(clk), .resetn(resetn), .trap(trap), .out_byte(out_byte), .out_byte_en(out_byte_en),
        .INT1(INT1), .INT2(INT2), .MISO(MISO), .MOSI(MOSI), .CS(CS), .SCLK(SCLK)
    );

    always #5 clk = ~clk;

`ifdef ASCII_HEX_EN
    localparam int N_STB = 12;
    logic [7:0] exp_stb [N_STB] = '{8'h31, 8'h30, 8'h0A, 8'h31, 8'h31, 8'h0A,
                                    8'h31, 8'h32, 8'h0A, 8'h31, 8'h33, 8'h0A};
`else
    localparam int N_STB = 4;
    logic [7:0] exp_stb [N_STB] = '{8'h10, 8'h11, 8'h12, 8'h13};
`endif

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // observation state, filled by the monitor
    int          rc = 0, per_first = 0;
    int          v_idle = 0, v_mosi = 0, v_per = 0, v_zero = 0, v_pulse = 0, v_trap = 0, v_hold = 0;
    int          v_cslow = 0, v_trapl = 0;
    longint      t_rise = 0, t_csr = -1;
    logic        p_cs = 1'b1, p_sclk = 1'b0, pp_sclk = 1'b0, p_mosi = 1'b0, p_en = 1'b0;
    logic [7:0]  p_out = '0, addr = '0, cmd = '0, bval;
    logic [23:0] sr = '0, sr24 = '0;
    int          e;
    int          rises[$];
    logic [23:0] mosi_q[$];
    longint      gaps[$];
    logic [7:0]  strobes[$];

    always @(negedge clk) begin
        if (CS && SCLK) v_idle++;
        if (!CS) v_cslow++;
        if (!trap) v_trapl++;
        if (!CS && p_cs) begin
            rc = 0;
            sr = '0;
            sr24 = '0;
            if (t_csr >= 0) gaps.push_back($time - t_csr);
        end
        if (CS && !p_cs) begin
            rises.push_back(rc);
            mosi_q.push_back(sr24);
            t_csr = $time;
        end
        if (!CS) begin
            if (!p_cs && MOSI != p_mosi && !(pp_sclk && !p_sclk)) v_mosi++;
            if (SCLK && !p_sclk) begin
                rc++;
                if (rc > 1 && $time - t_rise != 40) v_per++;
                if (rc == 2) per_first = int'($time - t_rise);
                t_rise = $time;
                sr = {sr[22:0], MOSI};
                if (rc == 8) cmd = sr[7:0];
                if (rc == 16) addr = sr[7:0];
                if (rc == 24) sr24 = sr;
                if (cmd == 8'h0B && rc > 16 && MOSI) v_zero++;
            end
            if ((p_sclk && !SCLK) || p_cs) begin
                e = rc + 1;
                MISO = 1'b0;
                if (cmd == 8'h0B && e >= 18) begin
                    bval = 8'(addr + 8'((e - 18) / 8));
                    MISO = bval[7 - ((e - 18) % 8)];
                end
            end
        end
        if (out_byte_en) begin
            strobes.push_back(out_byte);
            if (p_en) v_pulse++;
            if (trap) v_trap++;
        end
        if (resetn && !out_byte_en && out_byte != p_out) v_hold++;
        pp_sclk = p_sclk;
        p_sclk = SCLK;
        p_cs = CS;
        p_mosi = MOSI;
        p_en = out_byte_en;
        p_out = out_byte;
    end

    task automatic clear_obs();
        rises.delete();
        mosi_q.delete();
        gaps.delete();
        strobes.delete();
        v_idle = 0; v_mosi = 0; v_per = 0; v_zero = 0; v_pulse = 0; v_trap = 0; v_hold = 0;
        per_first = 0;
        t_csr = -1;
    endtask

    task automatic wait_trap(input string tag);
        int n = 0;
        while (!trap && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        check({tag, "_trap"}, trap, 1);
    endtask

    task automatic check_run(input string tag);
        check({tag, "_nwin"}, rises.size(), 2);
        check({tag, "_wr_rises"}, rises.size() > 0 ? rises[0] : -1, 24);
        check({tag, "_rd_rises"}, rises.size() > 1 ? rises[1] : -1, 49);
        check({tag, "_wr_mosi"}, mosi_q.size() > 0 ? mosi_q[0] : 24'hFFFFFF, 24'h0A2D02);
        check({tag, "_rd_mosi"}, mosi_q.size() > 1 ? mosi_q[1] : 24'hFFFFFF, 24'h0B1000);
        check({tag, "_gap_ge160"}, gaps.size() > 0 && gaps[0] >= 160, 1);
        check({tag, "_sclk_period"}, per_first, 40);
        check({tag, "_nstrobes"}, strobes.size(), N_STB);
        for (int i = 0; i < N_STB; i++)
            check($sformatf("%s_stb%0d", tag, i), i < strobes.size() ? {24'h0, strobes[i]} : 32'hFFFF, exp_stb[i]);
        check({tag, "_sclk_cs_idle"}, v_idle, 0);
        check({tag, "_mosi_timing"}, v_mosi, 0);
        check({tag, "_period_viol"}, v_per, 0);
        check({tag, "_mosi_zero"}, v_zero, 0);
        check({tag, "_pulse_gap"}, v_pulse, 0);
        check({tag, "_trap_early"}, v_trap, 0);
        check({tag, "_byte_hold"}, v_hold, 0);
    endtask

    initial begin
        int n;
        int ns;
        #1;
        check("por_cs", CS, 1);
        check("por_sclk", SCLK, 0);
        check("por_mosi", MOSI, 0);
        check("por_trap", trap, 0);
        check("por_en", out_byte_en, 0);
        check("por_byte", out_byte, 0);
        wait_trap("run1");
        check_run("run1");
        ns = strobes.size();
        v_cslow = 0;
        v_trapl = 0;
        repeat (1000) @(negedge clk);
        #1;
        check("hold_strobes", strobes.size(), ns);
        check("hold_cs_low", v_cslow, 0);
        check("hold_trap_low", v_trapl, 0);
        resetn = 1'b0;
        @(negedge clk); #1;
        check("rst_cs", CS, 1);
        check("rst_sclk", SCLK, 0);
        check("rst_mosi", MOSI, 0);
        check("rst_trap", trap, 0);
        check("rst_en", out_byte_en, 0);
        check("rst_byte", out_byte, 0);
        @(negedge clk); #1;
        clear_obs();
        resetn = 1'b1;
        n = 0;
        while (!(rises.size() == 1 && !CS && rc == 30) && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        check("abort_reach_edge30", n < 3000, 1);
        resetn = 1'b0;
        @(negedge clk); #1;
        check("abort_cs", CS, 1);
        check("abort_sclk", SCLK, 0);
        check("abort_trap", trap, 0);
        @(negedge clk); #1;
        check("abort_no_strobe", strobes.size(), 0);
        clear_obs();
        resetn = 1'b1;
        wait_trap("rerun");
        check_run("rerun");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
